// File: rtl/csr_trap_unit.sv
// Machine/supervisor trap CSR file with a trap-entry / xRET sequencer.
// Read data and ILLEGAL are registered; REDIRECT/NEXT_PC come straight from the sequencer state.
module csr_trap_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned CAUSE_BITS = 6,
  parameter int unsigned HAS_SMODE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            illegal,
  input  logic            trap_req,
  input  logic [XLEN-1:0] cause,
  input  logic [XLEN-1:0] tval,
  input  logic [XLEN-1:0] epc,
  input  logic            ret_req,
  input  logic [1:0]      ret_priv,
  output logic            busy,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc,
  output logic [1:0]      cur_priv
);

  localparam bit SOn = (HAS_SMODE != 0);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMedeleg  = 12'h302;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrSstatus  = 12'h100;
  localparam logic [11:0] AddrStvec    = 12'h105;
  localparam logic [11:0] AddrSscratch = 12'h140;
  localparam logic [11:0] AddrSepc     = 12'h141;
  localparam logic [11:0] AddrScause   = 12'h142;
  localparam logic [11:0] AddrStval    = 12'h143;
  localparam logic [11:0] AddrMcycle   = 12'hB00;

  typedef enum logic [1:0] {StIdle, StTSave, StTVec, StRRestore} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] medeleg_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] stvec_q, sscratch_q, sepc_q, scause_q, stval_q, mcycle_q;
  logic            sie_q, mie_q, spie_q, mpie_q, spp_q;
  logic [1:0]      mpp_q, cur_priv_q;

  logic [XLEN-1:0] cause_q, tval_q, epc_q;
  logic            tgt_s_q, ret_m_q;

  logic [XLEN-1:0] mstatus_val, sstatus_val, rd_val, tvec_base, vec_pc;
  logic            rd_ok, wr_act, wr_ok, wr_bad, ret_ok, deleg;
  logic            take_trap, take_ret, ret_bad;

  function automatic logic csr_exists(input logic [11:0] a);
    case (a)
      AddrMstatus, AddrMedeleg, AddrMtvec, AddrMscratch, AddrMepc, AddrMcause,
      AddrMtval, AddrMcycle: csr_exists = 1'b1;
      AddrSstatus, AddrStvec, AddrSscratch, AddrSepc, AddrScause,
      AddrStval: csr_exists = SOn;
      default: csr_exists = 1'b0;
    endcase
  endfunction

  // Only direct (0) and vectored (1) modes are legal; anything else falls back to direct.
  function automatic logic [XLEN-1:0] tvec_legal(input logic [XLEN-1:0] d);
    tvec_legal = {d[XLEN-1:2], 1'b0, d[1:0] == 2'b01};
  endfunction

  always_comb begin
    mstatus_val     = '0;
    mstatus_val[1]  = sie_q;
    mstatus_val[3]  = mie_q;
    mstatus_val[5]  = spie_q;
    mstatus_val[7]  = mpie_q;
    mstatus_val[8]  = spp_q;
    mstatus_val[12:11] = mpp_q;
    sstatus_val     = '0;
    sstatus_val[1]  = sie_q;
    sstatus_val[5]  = spie_q;
    sstatus_val[8]  = spp_q;
  end

  always_comb begin
    rd_val = '0;
    case (rd_addr)
      AddrMstatus:  rd_val = mstatus_val;
      AddrMedeleg:  rd_val = medeleg_q;
      AddrMtvec:    rd_val = mtvec_q;
      AddrMscratch: rd_val = mscratch_q;
      AddrMepc:     rd_val = mepc_q;
      AddrMcause:   rd_val = mcause_q;
      AddrMtval:    rd_val = mtval_q;
      AddrSstatus:  rd_val = sstatus_val;
      AddrStvec:    rd_val = stvec_q;
      AddrSscratch: rd_val = sscratch_q;
      AddrSepc:     rd_val = sepc_q;
      AddrScause:   rd_val = scause_q;
      AddrStval:    rd_val = stval_q;
      AddrMcycle:   rd_val = mcycle_q;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    rd_ok  = csr_exists(rd_addr) && (rd_addr[9:8] <= cur_priv_q);
    wr_act = wr_en && (state_q == StIdle);
    wr_ok  = wr_act && csr_exists(wr_addr) && (wr_addr[9:8] <= cur_priv_q) &&
             (wr_addr[11:10] != 2'b11);
    wr_bad = wr_act && !wr_ok;
    ret_ok = (ret_priv == 2'd3) ? (cur_priv_q == 2'd3) :
             (ret_priv == 2'd1) ? (SOn && (cur_priv_q != 2'd0)) : 1'b0;
    deleg  = SOn && (cur_priv_q <= 2'd1) && !cause[XLEN-1] &&
             medeleg_q[cause[CAUSE_BITS-1:0]];
    tvec_base = tgt_s_q ? stvec_q : mtvec_q;
    vec_pc    = {tvec_base[XLEN-1:2], 2'b00};
    if ((tvec_base[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      vec_pc = vec_pc + (XLEN'(cause_q[CAUSE_BITS-1:0]) << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    take_ret  = 1'b0;
    ret_bad   = 1'b0;
    busy      = (state_q != StIdle);
    redirect  = 1'b0;
    next_pc   = '0;
    unique case (state_q)
      StIdle: begin
        if (trap_req) begin
          take_trap = 1'b1;
          state_d   = StTSave;
        end else if (ret_req) begin
          if (ret_ok) begin
            take_ret = 1'b1;
            state_d  = StRRestore;
          end else begin
            ret_bad = 1'b1;
          end
        end
      end
      StTSave: state_d = StTVec;
      StTVec: begin
        redirect = 1'b1;
        next_pc  = vec_pc;
        state_d  = StIdle;
      end
      StRRestore: begin
        redirect = 1'b1;
        next_pc  = ret_m_q ? mepc_q : sepc_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cur_priv = cur_priv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data    <= '0;
      illegal    <= 1'b0;
      medeleg_q  <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
      mcycle_q   <= '0;
      sie_q      <= 1'b0;
      mie_q      <= 1'b0;
      spie_q     <= 1'b0;
      mpie_q     <= 1'b0;
      spp_q      <= 1'b0;
      mpp_q      <= 2'd0;
      cur_priv_q <= 2'd3;
      cause_q    <= '0;
      tval_q     <= '0;
      epc_q      <= '0;
      tgt_s_q    <= 1'b0;
      ret_m_q    <= 1'b0;
    end else begin
      rd_data  <= rd_ok ? rd_val : '0;
      illegal  <= !rd_ok || wr_bad || ret_bad;
      mcycle_q <= mcycle_q + XLEN'(1);
      if (wr_ok) begin
        case (wr_addr)
          AddrMstatus: begin
            sie_q  <= SOn && wr_data[1];
            mie_q  <= wr_data[3];
            spie_q <= SOn && wr_data[5];
            mpie_q <= wr_data[7];
            spp_q  <= SOn && wr_data[8];
            mpp_q  <= wr_data[12:11];
          end
          AddrSstatus: begin
            sie_q  <= wr_data[1];
            spie_q <= wr_data[5];
            spp_q  <= wr_data[8];
          end
          AddrMedeleg:  medeleg_q  <= wr_data;
          AddrMtvec:    mtvec_q    <= tvec_legal(wr_data);
          AddrMscratch: mscratch_q <= wr_data;
          AddrMepc:     mepc_q     <= {wr_data[XLEN-1:1], 1'b0};
          AddrMcause:   mcause_q   <= wr_data;
          AddrMtval:    mtval_q    <= wr_data;
          AddrStvec:    stvec_q    <= tvec_legal(wr_data);
          AddrSscratch: sscratch_q <= wr_data;
          AddrSepc:     sepc_q     <= {wr_data[XLEN-1:1], 1'b0};
          AddrScause:   scause_q   <= wr_data;
          AddrStval:    stval_q    <= wr_data;
          AddrMcycle:   mcycle_q   <= wr_data;
          default: ;
        endcase
      end
      if (take_trap) begin
        cause_q <= cause;
        tval_q  <= tval;
        epc_q   <= epc;
        tgt_s_q <= deleg;
      end
      if (take_ret) ret_m_q <= (ret_priv == 2'd3);
      if (state_q == StTSave) begin
        if (tgt_s_q) begin
          sepc_q     <= epc_q;
          scause_q   <= cause_q;
          stval_q    <= tval_q;
          spie_q     <= sie_q;
          sie_q      <= 1'b0;
          spp_q      <= cur_priv_q[0];
          cur_priv_q <= 2'd1;
        end else begin
          mepc_q     <= epc_q;
          mcause_q   <= cause_q;
          mtval_q    <= tval_q;
          mpie_q     <= mie_q;
          mie_q      <= 1'b0;
          mpp_q      <= cur_priv_q;
          cur_priv_q <= 2'd3;
        end
      end
      if (state_q == StRRestore) begin
        if (ret_m_q) begin
          cur_priv_q <= mpp_q;
          mie_q      <= mpie_q;
          mpie_q     <= 1'b1;
          mpp_q      <= 2'd0;
        end else begin
          cur_priv_q <= {1'b0, spp_q};
          sie_q      <= spie_q;
          spie_q     <= 1'b1;
          spp_q      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised successor CSR block holding the machine- and supervisor-level trap CSRs, plus a trap-entry/return sequencer.
- Sits beside the integer datapath. Serves CSR instruction reads/writes, performs trap entry with optional delegation and direct/vectored dispatch, and executes xRET.
- Gives the fetch unit a redirect PC and the current privilege level.

Parameters:
- XLEN, 64, data width of every CSR and of PC-valued ports (32 or 64).
- CAUSE_BITS, 6, low cause bits used for delegation index and vector offset.
- HAS_SMODE, 1, 1 = supervisor CSRs and delegation present; 0 = all traps to M, S addresses illegal.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- RD_ADDR  in  12  CSR read address
- RD_DATA  out  XLEN  registered read data
- WR_EN  in  1  CSR write strobe
- WR_ADDR  in  12  CSR write address
- WR_DATA  in  XLEN  CSR write data
- ILLEGAL  out  1  registered; access to the current RD/WR address is illegal
- TRAP_REQ  in  1  trap request pulse (exception or interrupt)
- CAUSE  in  XLEN  cause; MSB=1 means interrupt
- TVAL  in  XLEN  trap value
- EPC  in  XLEN  PC to save
- RET_REQ  in  1  xRET request pulse
- RET_PRIV  in  2  3 = MRET, 1 = SRET
- BUSY  out  1  sequencer not IDLE
- REDIRECT  out  1  one-cycle pulse; NEXT_PC valid
- NEXT_PC  out  XLEN  trap vector or return PC
- CUR_PRIV  out  2  current privilege (0 U, 1 S, 3 M)

Behaviour:
- Reset: all CSRs 0, CUR_PRIV=3, RD_DATA=0, ILLEGAL=0, BUSY=0, REDIRECT=0, NEXT_PC=0, state IDLE. Reset mid-sequence aborts with no CSR update.
- Implemented CSRs:
  - mstatus 0x300 (fields SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]; other bits read 0)
  - medeleg 0x302, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343
  - sstatus 0x100: masked view of mstatus, bits SIE/SPIE/SPP only
  - stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142, stval 0x143
  - mcycle 0xB00: increments every cycle, except a cycle where it is written.
- Read: RD_DATA <= CSR[RD_ADDR] one cycle after the address is presented.
- Read illegal: address unimplemented, or RD_ADDR[9:8] > CUR_PRIV. An illegal read returns 0 and sets ILLEGAL.
- Write illegal: additionally WR_ADDR[11:10]==2'b11 (read-only space). An illegal write is dropped and sets ILLEGAL.
- Write alignment: xepc writes force bit0=0; xtvec writes force bits[1:0] to 0 or 1 (value 2/3 stores 0).
- Write same-cycle: a write is visible to a read of the same address on the next cycle (write-before-read ordering at the clock edge).
- FSM states: IDLE, T_SAVE, T_VEC, R_RESTORE.
- IDLE:
  - TRAP_REQ -> T_SAVE. Latch CAUSE/TVAL/EPC.
  - Target S if HAS_SMODE, CUR_PRIV<=1, CAUSE MSB=0 and medeleg[CAUSE[CAUSE_BITS-1:0]]=1; otherwise target M.
  - RET_REQ -> R_RESTORE.
  - TRAP_REQ and RET_REQ together: trap wins, RET dropped.
- T_SAVE (target x):
  - xepc=EPC, xcause=CAUSE, xtval=TVAL.
  - xPIE=xIE, xIE=0, xPP=CUR_PRIV (SPP stores CUR_PRIV[0]).
  - CUR_PRIV=x. Next state T_VEC.
- T_VEC:
  - NEXT_PC = {xtvec[XLEN-1:2],2'b00}.
  - If xtvec[1:0]==1 and CAUSE MSB=1, add 4*CAUSE[CAUSE_BITS-1:0], modulo 2^XLEN.
  - REDIRECT=1 for this cycle; next state IDLE.
- R_RESTORE:
  - MRET: CUR_PRIV=MPP, MIE=MPIE, MPIE=1, MPP=0, NEXT_PC=mepc.
  - SRET: CUR_PRIV={1'b0,SPP}, SIE=SPIE, SPIE=1, SPP=0, NEXT_PC=sepc.
  - REDIRECT=1; next state IDLE.
  - Illegal return: MRET with CUR_PRIV<3, or SRET with CUR_PRIV==0 (or with HAS_SMODE=0). It sets ILLEGAL, performs no state change, no REDIRECT.
- Trap latency: REDIRECT 2 cycles after TRAP_REQ. Return latency: 1 cycle.
- While BUSY:
  - WR_EN is ignored (not flagged illegal).
  - TRAP_REQ/RET_REQ are ignored; the requester must hold off.
  - Reads continue.

Test Plan:
- Reset, then read 0x300, 0x305 and CUR_PRIV -> RD_DATA=0, CUR_PRIV=3, ILLEGAL=0.
- Set mtvec=0x8000_0001 in M mode. Trap with CAUSE=0x8000..0007 (interrupt 7), EPC=0x1234 -> REDIRECT on cycle+2, NEXT_PC=0x8000_001C, mepc=0x1234, MIE=0, MPP=3.
- Set medeleg bit 2, stvec=0x4000. Enter U via MRET with MPP=0. Trap CAUSE=2 -> target S, NEXT_PC=0x4000, sepc=EPC, SPP=0, CUR_PRIV=1, mcause unchanged.
- In S mode: read 0x342 -> ILLEGAL=1, RD_DATA=0. Write 0xB00 -> dropped, ILLEGAL=1. SRET -> CUR_PRIV=0, NEXT_PC=sepc one cycle later.
- TRAP_REQ and RET_REQ in the same cycle; WR_EN to mscratch during T_SAVE -> trap taken, return dropped, mscratch unchanged.
- Assert RESET during T_SAVE -> next cycle all outputs are their reset values and mepc=0.
